// File: rtl/joy_serial_reader_if.sv
// Lines between the reader and a daisy-chained 74x165 joystick adapter.
// The master drives shift clock and active-low load; the adapter returns serial data.
interface joy_serial_reader_if;
    logic joy_clk;
    logic joy_load;
    logic joy_data;

    modport master (output joy_clk, output joy_load, input joy_data);
    modport slave  (input joy_clk, input joy_load, output joy_data);
endinterface

// File: rtl/joy_serial_reader.sv
// Serial joystick front end: scans N players of W bits from a 74x165 chain,
// filters frames for stability and flags disconnected players.
module joy_serial_reader #(
    parameter int NUM_PLAYERS     = 2,
    parameter int BITS_PER_PLAYER = 12,
    parameter int CLK_DIV         = 8,
    parameter int STABLE_FRAMES   = 2
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   enable,
    joy_serial_reader_if.master                    joy,
    output logic [NUM_PLAYERS*BITS_PER_PLAYER-1:0] joystick,
    output logic [NUM_PLAYERS-1:0]                 present,
    output logic                                   frame_strobe
);
    localparam int W  = BITS_PER_PLAYER;
    localparam int T  = NUM_PLAYERS * W;
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(T);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(T - 1);
    localparam logic [3:0]    STABLE     = 4'(STABLE_FRAMES);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        SHIFT_LO,
        SHIFT_HI,
        COMMIT
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [PW-1:0]          presc;
    logic                   tick;
    logic [1:0]             sync;
    logic [BW-1:0]          bitcnt;
    logic [T-1:0]           raw;
    logic [T-1:0]           prev_raw;
    logic [3:0]             match_cnt;
    logic [3:0]             match_next;
    logic [T-1:0]           joy_next;
    logic [NUM_PLAYERS-1:0] present_next;
    logic                   joy_clk_r;
    logic                   joy_load_r;

    assign tick         = (presc == PRESC_LAST);
    assign joy.joy_clk  = joy_clk_r;
    assign joy.joy_load = joy_load_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
            sync  <= 2'b11;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            sync  <= {sync[0], joy.joy_data};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (tick) begin
            case (state)
                IDLE:     if (enable) state_next = LOAD;
                LOAD:     state_next = SETTLE;
                SETTLE:   state_next = SHIFT_LO;
                SHIFT_LO: state_next = SHIFT_HI;
                SHIFT_HI: state_next = (bitcnt < BIT_LAST) ? SHIFT_LO : COMMIT;
                COMMIT:   state_next = enable ? LOAD : IDLE;
                default:  state_next = IDLE;
            endcase
        end
    end

    // An all-ones slice means every line reads pressed, which only an unplugged adapter produces.
    always_comb begin
        match_next   = 4'd1;
        joy_next     = raw;
        present_next = '0;
        if (raw == prev_raw)
            match_next = (match_cnt >= STABLE) ? STABLE : match_cnt + 4'd1;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            present_next[p] = ~&raw[p*W +: W];
            if (!present_next[p])
                joy_next[p*W +: W] = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            joy_clk_r    <= 1'b0;
            joy_load_r   <= 1'b1;
            bitcnt       <= '0;
            raw          <= '0;
            prev_raw     <= '0;
            match_cnt    <= '0;
            joystick     <= '0;
            present      <= '0;
            frame_strobe <= 1'b0;
        end else begin
            frame_strobe <= 1'b0;
            if (tick) begin
                case (state)
                    IDLE: begin
                        if (enable) joy_load_r <= 1'b0;
                    end
                    LOAD: begin
                        joy_load_r <= 1'b1;
                    end
                    SETTLE: begin
                        bitcnt <= '0;
                    end
                    SHIFT_LO: begin
                        raw[bitcnt] <= ~sync[1];
                        joy_clk_r   <= 1'b1;
                    end
                    SHIFT_HI: begin
                        joy_clk_r <= 1'b0;
                        bitcnt    <= bitcnt + 1'b1;
                    end
                    COMMIT: begin
                        frame_strobe <= 1'b1;
                        prev_raw     <= raw;
                        match_cnt    <= match_next;
                        if (match_next == STABLE) begin
                            joystick <= joy_next;
                            present  <= present_next;
                        end
                        if (enable) joy_load_r <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
